// File: rtl/req_arbiter_ctrl_pkg.sv
// Shared encodings for the request arbiter: FSM states, arbitration modes, requester count.
package req_arbiter_ctrl_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_REL   = 2'b10
  } state_t;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/req_arbiter_ctrl_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface req_arbiter_ctrl_if;
  import req_arbiter_ctrl_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic               rr_mode;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_id;
  logic               busy;
  logic               timeout;

  modport master (output req, done, rr_mode, input grant, grant_id, busy, timeout);
  modport slave  (input req, done, rr_mode, output grant, grant_id, busy, timeout);
endinterface

// File: rtl/req_arbiter_ctrl_prio_enc4.sv
// 4-bit priority encoder, highest set bit wins; vld low when no bit is set.
module prio_enc4 (
  input  logic [3:0] in,
  output logic [1:0] idx,
  output logic       vld
);

  always_comb begin
    idx = 2'd0;
    vld = 1'b1;
    if (in[3])      idx = 2'd3;
    else if (in[2]) idx = 2'd2;
    else if (in[1]) idx = 2'd1;
    else if (in[0]) idx = 2'd0;
    else            vld = 1'b0;
  end

endmodule

// File: rtl/req_arbiter_ctrl.sv
// Four-way arbiter with fixed/round-robin selection, hold limit with forced release,
// and a one-cycle turnaround between grants. All outputs registered.
module req_arbiter_ctrl
  import req_arbiter_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  req_arbiter_ctrl_if.slave  bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [1:0] last_id;

  logic [7:0] req_dbl;
  logic [7:0] req_rot;
  logic [3:0] enc_in;
  logic [1:0] enc_idx;
  logic       enc_vld;
  logic [1:0] winner;
  logic       owner_req;
  logic       hit_limit;
  logic       release_now;
  logic       force_rel;

  // Rotating right by last_id puts (last_id-1) at the top so the encoder's
  // highest-bit rule yields the round-robin order; adding last_id undoes it.
  always_comb begin
    req_dbl = {bus.req, bus.req};
    req_rot = req_dbl >> last_id;
    enc_in  = (mode_t'(bus.rr_mode) == MODE_RR) ? req_rot[3:0] : bus.req;
    winner  = (mode_t'(bus.rr_mode) == MODE_RR) ? enc_idx + last_id : enc_idx;
  end

  prio_enc4 u_enc (
    .in  (enc_in),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    owner_req   = bus.req[bus.grant_id];
    hit_limit   = (hold_cnt == HOLD_LAST);
    release_now = bus.done || !owner_req || hit_limit;
    force_rel   = hit_limit && !bus.done && owner_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      last_id      <= '0;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.timeout <= 1'b0;
          if (enc_vld) begin
            state        <= ST_GRANT;
            hold_cnt     <= '0;
            bus.grant    <= onehot(winner);
            bus.grant_id <= winner;
            bus.busy     <= 1'b1;
          end
        end
        ST_GRANT: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (release_now) begin
            state       <= ST_REL;
            last_id     <= bus.grant_id;
            bus.grant   <= '0;
            bus.timeout <= force_rel;
          end
        end
        ST_REL: begin
          state       <= ST_IDLE;
          bus.busy    <= 1'b0;
          bus.timeout <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          bus.grant   <= '0;
          bus.busy    <= 1'b0;
          bus.timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter_ctrl.sv
// Randomized and directed checks of req_arbiter_ctrl against a transaction-level reference model.
module tb_req_arbiter_ctrl;
  import req_arbiter_ctrl_pkg::*;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  req_arbiter_ctrl_if ifc ();

  req_arbiter_ctrl #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: phase 0=idle,1=owner holds bus,2=turnaround; held = grant cycles seen so far.
  int m_phase, m_owner, m_last, m_held;
  bit m_to;

  function automatic int pick(input logic [3:0] r, input bit rr, input int last);
    if (!rr) begin
      for (int i = 3; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int s = 1; s <= 4; s++) begin
        int c;
        c = (last - s + 8) % 4;
        if (r[c]) return c;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit owner_on;
    case (m_phase)
      0: begin
        m_to = 0;
        if (ifc.req != 4'b0) begin
          m_owner = pick(ifc.req, ifc.rr_mode, m_last);
          m_phase = 1;
          m_held  = 1;
        end
      end
      1: begin
        owner_on = ifc.req[m_owner];
        if (ifc.done || !owner_on || m_held == MH) begin
          m_to    = !ifc.done && owner_on && (m_held == MH);
          m_phase = 2;
          m_last  = m_owner;
        end else begin
          m_held++;
        end
      end
      default: begin
        m_phase = 0;
        m_to    = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [3:0] exp_g;
    exp_g = (m_phase == 1) ? 4'(1 << m_owner) : 4'b0;
    check("grant", ifc.grant, exp_g);
    check("grant_id", ifc.grant_id, m_owner);
    check("busy", ifc.busy, m_phase != 0);
    check("timeout", ifc.timeout, m_to);
  endtask

  task automatic cyc(input logic [3:0] r, input logic d, input logic m);
    ifc.req = r; ifc.done = d; ifc.rr_mode = m;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    ifc.req = 4'b0; ifc.done = 1'b0; ifc.rr_mode = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int ids[$];
    int gaps[$];
    int zeros;
    int ghigh;
    logic [3:0] prev_g;
    logic [3:0] r;
    logic d, m;

    rst_n = 1'b0;
    do_reset();

    // Fixed mode, 0110 held, done on third grant cycle.
    cyc(4'b0110, 1'b0, 1'b0);
    check("s32_first_grant", ifc.grant, 4'b0100);
    check("s32_first_id", ifc.grant_id, 2);
    cyc(4'b0110, 1'b0, 1'b0);
    cyc(4'b0110, 1'b1, 1'b0);
    check("s32_rel_grant", ifc.grant, 4'b0);
    check("s32_rel_busy", ifc.busy, 1);
    cyc(4'b0110, 1'b0, 1'b0);
    cyc(4'b0110, 1'b0, 1'b0);
    check("s32_regrant", ifc.grant, 4'b0100);
    cyc(4'b0000, 1'b1, 1'b0);
    idle_cycles(2);

    // Round robin, all requesting, done every grant cycle.
    do_reset();
    prev_g = 4'b0;
    zeros = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(4'b1111, 1'b1, 1'b1);
      if (ifc.grant != 4'b0 && prev_g == 4'b0) begin
        ids.push_back(int'(ifc.grant_id));
        if (ids.size() > 1) gaps.push_back(zeros);
        zeros = 0;
      end else if (ifc.grant == 4'b0) begin
        zeros++;
      end
      prev_g = ifc.grant;
    end
    check("s33_count", ids.size() >= 5, 1);
    if (ids.size() >= 5) begin
      check("s33_id0", ids[0], 3);
      check("s33_id1", ids[1], 2);
      check("s33_id2", ids[2], 1);
      check("s33_id3", ids[3], 0);
      check("s33_id4", ids[4], 3);
      for (int i = 0; i < 4; i++) check("s33_gap", gaps[i], 2);
    end
    idle_cycles(3);

    // Hold limit with no done: forced release.
    do_reset();
    ghigh = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0001, 1'b0, 1'b0);
      if (ifc.grant == 4'b0001) ghigh++;
    end
    check("s34_hold_cycles", ghigh, 4);
    check("s34_timeout", ifc.timeout, 1);
    cyc(4'b0001, 1'b0, 1'b0);
    check("s34_timeout_pulse", ifc.timeout, 0);
    cyc(4'b0001, 1'b0, 1'b0);
    check("s34_regrant", ifc.grant, 4'b0001);
    cyc(4'b0001, 1'b1, 1'b0);
    idle_cycles(2);

    // Owner drops its request while a higher one is pending.
    do_reset();
    cyc(4'b0100, 1'b0, 1'b0);
    check("s35_owner", ifc.grant_id, 2);
    cyc(4'b1000, 1'b0, 1'b0);
    check("s35_rel_grant", ifc.grant, 4'b0);
    check("s35_rel_timeout", ifc.timeout, 0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    check("s35_next_id", ifc.grant_id, 3);
    cyc(4'b0000, 1'b1, 1'b0);
    idle_cycles(2);

    // Asynchronous reset in the middle of a grant.
    cyc(4'b0010, 1'b0, 1'b0);
    check("s36_pre_grant", ifc.grant, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("s36_async_grant", ifc.grant, 4'b0);
    check("s36_async_busy", ifc.busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0010, 1'b0, 1'b0);
    check("s36_regrant", ifc.grant, 4'b0010);
    cyc(4'b0010, 1'b1, 1'b0);
    idle_cycles(2);

    // Done coincides with the hold limit.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b1, 1'b0);
    check("s37_grant", ifc.grant, 4'b0);
    check("s37_timeout", ifc.timeout, 0);
    idle_cycles(2);

    // Randomized traffic.
    r = 4'b0; m = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) m = ~m;
      d = ($urandom_range(0, 3) == 0);
      if (i % 150 == 149) do_reset();
      cyc(r, d, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
